// File: rtl/arb_pkg.sv
// Shared types and constants for the 8-way round-robin arbiter.
package arb_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned IDX_W = 3;

  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic [0:0] {
    Idle  = 1'b0,
    Owned = 1'b1
  } arb_state_e;

  // Position of the lowest set bit; 0 when the vector is empty.
  function automatic idx_t lsb_idx(input logic [N_REQ-1:0] v);
    idx_t r;
    r = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (v[i]) r = idx_t'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_prio_enc_8.sv
// Combinational round-robin priority encoder: first set request at or above ptr_i,
// wrapping from 7 back to 0.
module rr_prio_enc_8
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req_i,
  input  idx_t             ptr_i,
  output logic             found_o,
  output idx_t             idx_o
);

  logic [N_REQ-1:0] rot;
  idx_t             rot_idx;

  // Rotate so ptr_i lands on bit 0, pick the lowest set bit, then rotate the index back.
  always_comb begin
    rot     = N_REQ'({req_i, req_i} >> ptr_i);
    rot_idx = lsb_idx(rot);
    found_o = |req_i;
    idx_o   = rot_idx + ptr_i;
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// 8-requester round-robin arbiter with a hold limit and one idle turnaround cycle
// between consecutive grants. All outputs are registered.
module rr_arbiter_8
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  localparam logic [7:0] HoldLast = 8'(MAX_HOLD - 1);

  arb_state_e       state_q, state_d;
  idx_t             ptr_q, ptr_d;
  logic [7:0]       hold_cnt_q, hold_cnt_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  idx_t             gnt_idx_q, gnt_idx_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic             timeout_q, timeout_d;

  logic             win_found;
  idx_t             win_idx;

  rr_prio_enc_8 u_prio_enc (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .found_o (win_found),
    .idx_o   (win_idx)
  );

  // Next-state: arbitrate in Idle, hold or release (voluntary or forced) in Owned.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    hold_cnt_d  = hold_cnt_q;
    gnt_d       = gnt_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;

    unique case (state_q)
      Idle: begin
        if (win_found) begin
          state_d     = Owned;
          gnt_d       = N_REQ'(1) << win_idx;
          gnt_idx_d   = win_idx;
          gnt_valid_d = 1'b1;
          hold_cnt_d  = '0;
        end
      end
      Owned: begin
        if (!req[gnt_idx_q] || (hold_cnt_q == HoldLast)) begin
          // Release always returns to Idle, which gives the turnaround cycle.
          state_d     = Idle;
          gnt_d       = '0;
          gnt_idx_d   = '0;
          gnt_valid_d = 1'b0;
          hold_cnt_d  = '0;
          ptr_d       = gnt_idx_q + idx_t'(1);
          timeout_d   = req[gnt_idx_q];
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
    endcase
  end

  // State, pointer, hold counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= Idle;
      ptr_q       <= '0;
      hold_cnt_q  <= '0;
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      hold_cnt_q  <= hold_cnt_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed bench for rr_arbiter_8 with hand-computed expected grants.
module tb_rr_arbiter_8;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] req   = 8'h00;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;
  logic       done  = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rr_arbiter_8 #(.MAX_HOLD(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] enc(input logic [7:0] g);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) if (g[i]) r = 3'(i);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_gnt(input string tag, input logic [7:0] g, input logic to);
    check({tag, ".gnt"}, 32'(gnt), 32'(g));
    check({tag, ".idx"}, 32'(gnt_idx), 32'(enc(g)));
    check({tag, ".valid"}, 32'(gnt_valid), 32'(g != 8'h00));
    check({tag, ".timeout"}, 32'(timeout), 32'(to));
  endtask

  // Per-cycle invariants: at most one grant bit, valid tracks it, index matches it.
  always @(negedge clk) begin
    if (rst_n && !done) begin
      check("onehot0", 32'($onehot0(gnt)), 32'd1);
      check("valid_or", 32'(gnt_valid), 32'(|gnt));
      check("idx_enc", 32'(gnt_idx), 32'(enc(gnt)));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    #1 rst_n = 1'b0;
    #1 expect_gnt("reset", 8'h00, 1'b0);
    step();
    step();
    rst_n = 1'b1;

    // Single requester: 16-cycle hold, timeout, one idle cycle, re-grant
    req = 8'h01;
    step();
    expect_gnt("solo.first", 8'h01, 1'b0);
    for (int i = 1; i < 16; i++) begin
      step();
      expect_gnt($sformatf("solo.hold%0d", i), 8'h01, 1'b0);
    end
    step();
    expect_gnt("solo.timeout", 8'h00, 1'b1);
    step();
    expect_gnt("solo.regrant", 8'h01, 1'b0);
    req = 8'h00;
    step();
    expect_gnt("solo.release", 8'h00, 1'b0);

    // Fresh reset so round-robin order starts from 0
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;

    // All requesting, each owner drops after 3 cycles: 0..7,0
    req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      int o;
      o = k % 8;
      step();
      expect_gnt($sformatf("rr%0d.c1", k), 8'h01 << o, 1'b0);
      step();
      expect_gnt($sformatf("rr%0d.c2", k), 8'h01 << o, 1'b0);
      step();
      expect_gnt($sformatf("rr%0d.c3", k), 8'h01 << o, 1'b0);
      req[o] = 1'b0;
      step();
      expect_gnt($sformatf("rr%0d.gap", k), 8'h00, 1'b0);
      req = (k < 8) ? 8'hFF : 8'h00;
    end

    // ptr=1: owner 5 then release leaves ptr=6; req 0101 wraps to 0, then 2
    req = 8'h20;
    step();
    expect_gnt("wrap.own5", 8'h20, 1'b0);
    req = 8'h00;
    step();
    expect_gnt("wrap.rel5", 8'h00, 1'b0);
    req = 8'h05;
    step();
    expect_gnt("wrap.g0", 8'h01, 1'b0);
    req = 8'h04;
    step();
    expect_gnt("wrap.rel0", 8'h00, 1'b0);
    step();
    expect_gnt("wrap.g2", 8'h04, 1'b0);
    req = 8'h00;
    step();
    expect_gnt("wrap.rel2", 8'h00, 1'b0);

    // ptr=3: others rising during owner 3 are ignored; then 7, then 1
    req = 8'h08;
    step();
    expect_gnt("late.g3", 8'h08, 1'b0);
    req = 8'h8A;
    step();
    expect_gnt("late.hold3a", 8'h08, 1'b0);
    step();
    expect_gnt("late.hold3b", 8'h08, 1'b0);
    req = 8'h82;
    step();
    expect_gnt("late.rel3", 8'h00, 1'b0);
    step();
    expect_gnt("late.g7", 8'h80, 1'b0);
    req = 8'h02;
    step();
    expect_gnt("late.rel7", 8'h00, 1'b0);
    step();
    expect_gnt("late.g1", 8'h02, 1'b0);
    req = 8'h00;
    step();
    expect_gnt("late.rel1", 8'h00, 1'b0);

    // Async reset mid-grant of owner 4
    req = 8'h10;
    step();
    expect_gnt("arst.g4", 8'h10, 1'b0);
    #2 rst_n = 1'b0;
    #1 expect_gnt("arst.now", 8'h00, 1'b0);
    step();
    expect_gnt("arst.held", 8'h00, 1'b0);
    rst_n = 1'b1;
    step();
    expect_gnt("arst.regrant4", 8'h10, 1'b0);

    // Owner 4 revoked by timeout while 0 also requests: ptr=5 search picks 0
    req = 8'h11;
    for (int i = 1; i < 16; i++) begin
      step();
      expect_gnt($sformatf("revoke.hold%0d", i), 8'h10, 1'b0);
    end
    step();
    expect_gnt("revoke.timeout", 8'h00, 1'b1);
    step();
    expect_gnt("revoke.g0", 8'h01, 1'b0);
    req = 8'h00;
    step();
    expect_gnt("revoke.rel0", 8'h00, 1'b0);

    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
